// File: rtl/vit_accel_pkg.sv
// Shared accelerator definitions: PE row engine FSM encoding and Q8.8 saturation limits.
package vit_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pe_state_e;

  localparam int          Q88_W   = 16;
  localparam logic [15:0] Q88_MAX = 16'h7FFF;
  localparam logic [15:0] Q88_MIN = 16'h8000;

endpackage

// File: rtl/pe_row_engine_if.sv
// Job/operand/result bundle between attention_block (master) and pe_row_engine (slave).
interface pe_row_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_MACS   = 4
);
  logic                             pe_start;
  logic [15:0]                      workload_cols;
  logic                             in_valid;
  logic [NUM_MACS*DATA_WIDTH-1:0]   embed_data;
  logic [NUM_MACS*DATA_WIDTH-1:0]   weight_data;
  logic                             busy;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_valid;
  logic                             pe_done;

  modport master (
    output pe_start, workload_cols, in_valid, embed_data, weight_data,
    input  busy, out_data, out_valid, pe_done
  );

  modport slave (
    input  pe_start, workload_cols, in_valid, embed_data, weight_data,
    output busy, out_data, out_valid, pe_done
  );
endinterface

// File: rtl/pe_row_engine_mac_lane.sv
// One MAC lane: signed multiply, optional zero-mask on the tail beat, accumulate, clear.
module mac_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         mask,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]         acc
);
  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]  prod;
  logic [ACC_WIDTH-1:0]  prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= acc + (mask ? '0 : prod_ext);
  end
endmodule

// File: rtl/pe_row_engine.sv
// Row dot-product engine: NUM_MACS parallel lanes, registered adder tree, Q-format saturation.
module pe_row_engine
  import vit_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_MACS   = 4,
  parameter int ACC_WIDTH  = 40,
  parameter int FRAC_BITS  = 8
) (
  input logic           clk,
  input logic           rst,
  pe_row_engine_if.slave bus
);
  localparam int LOG2   = $clog2(NUM_MACS);
  localparam int HALF   = NUM_MACS / 2;
  localparam int STAGES = LOG2 - 1;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX =
    (DATA_WIDTH == Q88_W) ? DATA_WIDTH'(Q88_MAX) : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN =
    (DATA_WIDTH == Q88_W) ? DATA_WIDTH'(Q88_MIN) : {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'($signed(SAT_MAX));
  localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'($signed(SAT_MIN));

  typedef logic [STAGES:0] pipe_t;

  pe_state_e                                   state, nxt;
  logic [15:0]                                 cols_q;
  logic [15:0]                                 beat_cnt;
  pipe_t                                       vld_pipe;
  logic [NUM_MACS-1:0][ACC_WIDTH-1:0]          acc;
  logic [LOG2-1:0][HALF-1:0][ACC_WIDTH-1:0]    tree_q;
  logic [NUM_MACS-1:0]                         lane_mask;
  logic [DATA_WIDTH-1:0]                       out_hold, sat_val;
  logic [16:0]                                 beats_total;
  logic [LOG2-1:0]                             rem;
  logic                                        accept, beat, last_beat;
  logic signed [ACC_WIDTH-1:0]                 tree_sum, shifted;

  assign beats_total = ({1'b0, cols_q} + 17'(NUM_MACS - 1)) >> LOG2;
  assign rem         = cols_q[LOG2-1:0];
  assign accept      = (state == ST_IDLE) && bus.pe_start;
  assign beat        = (state == ST_ACCUM) && bus.in_valid;
  assign last_beat   = beat && ({1'b0, beat_cnt} == beats_total - 17'd1);

  for (genvar g = 0; g < NUM_MACS; g++) begin : g_lane
    // Only the final beat of a job with a ragged length drops its upper lanes.
    assign lane_mask[g] = last_beat && (rem != '0) && (LOG2'(g) >= rem);

    mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (beat),
      .mask (lane_mask[g]),
      .a    (bus.embed_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .b    (bus.weight_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .acc  (acc[g])
    );
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (bus.pe_start) nxt = (bus.workload_cols == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (last_beat) nxt = ST_DRAIN;
      ST_DRAIN: if (vld_pipe[STAGES]) nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cols_q   <= '0;
      beat_cnt <= '0;
      vld_pipe <= '0;
      out_hold <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        cols_q   <= bus.workload_cols;
        beat_cnt <= '0;
        vld_pipe <= '0;
      end else begin
        if (beat) beat_cnt <= beat_cnt + 16'd1;
        vld_pipe <= (vld_pipe << 1) | pipe_t'(last_beat);
      end
      if (state == ST_DONE) out_hold <= sat_val;
    end
  end

  // Every level recomputes each DRAIN cycle; accumulators are frozen, so after LOG2 edges the root is exact.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      tree_q <= '0;
    end else if (state == ST_DRAIN) begin
      for (int i = 0; i < HALF; i++)
        tree_q[0][i] <= acc[2*i] + acc[2*i+1];
      for (int l = 1; l < LOG2; l++)
        for (int i = 0; i < HALF; i++)
          if (2*i+1 < HALF)
            tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
    end
  end

  assign tree_sum = tree_q[LOG2-1][0];
  assign shifted  = tree_sum >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[DATA_WIDTH-1:0];
    if (shifted > HI)      sat_val = SAT_MAX;
    else if (shifted < LO) sat_val = SAT_MIN;
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.pe_done   = (state == ST_DONE);
  assign bus.out_data  = (state == ST_DONE) ? sat_val : out_hold;
endmodule

// File: doc/pe_row_engine.md
PE_ROW_ENGINE -- requirements
Module: pe_row_engine

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 16, signed Q8.8 element width.
REQ-002 SHALL take parameter NUM_MACS, default 4, parallel lanes; power of two, at least 2.
REQ-003 SHALL take parameter ACC_WIDTH, default 40, per-lane accumulator width.
REQ-004 SHALL take parameter FRAC_BITS, default 8, fractional bits of operands and result.
REQ-005 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-007 SHALL have port pe_start, input, 1 bit; job request from attention_block.
REQ-008 SHALL have port workload_cols, input, 16 bits; dot-product length, sampled with pe_start.
REQ-009 SHALL have port in_valid, input, 1 bit; operand beat valid.
REQ-010 SHALL have port embed_data, input, NUM_MACS*DATA_WIDTH bits; embedding lanes, lane 0 in LSBs.
REQ-011 SHALL have port weight_data, input, NUM_MACS*DATA_WIDTH bits; weight lanes, same packing.
REQ-012 SHALL have port busy, output, 1 bit; high from job acceptance until pe_done.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits; saturated dot-product result.
REQ-014 SHALL have port out_valid, output, 1 bit; one-cycle result strobe.
REQ-015 SHALL have port pe_done, output, 1 bit; one-cycle completion pulse to attention_block.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, DRAIN, DONE.
REQ-017 In IDLE, pe_start with workload_cols>0 SHALL latch workload_cols, clear all accumulators and the beat counter, and enter ACCUM next cycle.
REQ-018 In IDLE, pe_start with workload_cols==0 SHALL enter DONE next cycle with out_data=0.
REQ-019 Beat count SHALL be ceil(workload_cols/NUM_MACS); each cycle in ACCUM with in_valid high consumes one beat; in_valid low stalls with no state change.
REQ-020 Each lane SHALL add the full-precision signed product embed*weight, sign-extended to ACC_WIDTH.
REQ-021 On the final beat, lanes with index >= (workload_cols mod NUM_MACS) SHALL contribute zero when that remainder is non-zero.
REQ-022 After the final beat, the engine SHALL enter DRAIN for exactly log2(NUM_MACS) cycles, one registered adder-tree level per cycle.
REQ-023 Tree result SHALL be arithmetically right-shifted by FRAC_BITS, then saturated to signed DATA_WIDTH (0x7FFF / 0x8000 for 16 bits).
REQ-024 DONE SHALL last one cycle, assert out_valid and pe_done together with out_data valid, then return to IDLE.
REQ-025 pe_done SHALL therefore be asserted log2(NUM_MACS)+1 cycles after the edge that accepted the final beat.
REQ-026 pe_start outside IDLE SHALL be ignored; in_valid outside ACCUM SHALL be ignored.
REQ-027 out_data SHALL hold its last value until the next DONE.
REQ-028 busy SHALL be high in ACCUM, DRAIN and DONE, low in IDLE.

Reset
REQ-029 rst SHALL force IDLE and zero accumulators, beat counter, tree registers, out_data, busy, out_valid, pe_done.
REQ-030 rst mid-job SHALL abort without pe_done; rst SHALL take priority over pe_start in the same cycle.

Structure
REQ-031 FSM state encodings and the Q8.8 saturation limits SHALL live in shared package vit_accel_pkg.
REQ-032 A sub-module mac_lane (multiply, mask, accumulate, clear) SHALL be instantiated NUM_MACS times; adder tree and FSM SHALL stay in pe_row_engine.

Verification
REQ-033 cols=8, all embed 0x0100, weight 0x0200, in_valid continuous -> out_data 0x1000, pe_done 3 cycles after the 2nd beat.
REQ-034 cols=6, all lanes 0x0100 x 0x0100, 2 beats -> out_data 0x0600 (lanes 2,3 masked on beat 2).
REQ-035 cols=4, all 0x7F00 x 0x7F00 -> 0x7FFF; embed 0x8100, weight 0x7F00 -> 0x8000.
REQ-036 cols=0 pe_start -> pe_done and out_valid the next cycle, out_data 0x0000, busy high that cycle only.
REQ-037 cols=8 with in_valid low 3 cycles between beats, plus pe_start pulsed in ACCUM -> result 0x1000, second pe_start ignored.
REQ-038 rst asserted after first beat of cols=8 job -> no pe_done, busy 0; new cols=4 job of 0x0100 x 0x0100 -> 0x0400.
